// File: rtl/hdmi_timing_pkg.sv
// Shared constants for the 640x480@60 HDMI timing path: VESA timing, FSM states, colour bars.
package hdmi_timing_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam bit          VGA_SYNC_POL = 1'b0;
  localparam int unsigned VGA_DEBOUNCE = 252000;
  localparam int unsigned VGA_CNT_W    = 10;

  localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // Colour bars, left to right.
  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    logic [23:0] c;
    unique case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hdmi_timing_ctrl_if.sv
// Video timing bundle from the sequencer to the TMDS encoders.
interface hdmi_timing_ctrl_if #(
  parameter int unsigned CNT_W = 10
);
  logic [CNT_W-1:0] pixel_x;
  logic [CNT_W-1:0] pixel_y;
  logic             de;
  logic             hsync;
  logic             vsync;
  logic             frame_start;
  logic             white_mode;
  logic [23:0]      rgb;

  modport master (
    output pixel_x, pixel_y, de, hsync, vsync, frame_start, white_mode, rgb
  );
  modport slave (
    input pixel_x, pixel_y, de, hsync, vsync, frame_start, white_mode, rgb
  );
endinterface

// File: rtl/hdmi_timing_ctrl_btn_debounce.sv
// Pushbutton conditioning: 2-FF synchronizer followed by a stable-count debouncer.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 252000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic i_btn,
  output logic o_level
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1, r_s2, r_level, w_level_d;
  logic [CW-1:0] r_cnt, w_cnt_d;

  // r_cnt counts consecutive synchronized samples that disagree with the current level.
  always_comb begin
    w_cnt_d   = r_cnt;
    w_level_d = r_level;
    if (r_s2 == r_level) begin
      w_cnt_d = '0;
    end else if (r_cnt == CNT_LAST) begin
      w_level_d = r_s2;
      w_cnt_d   = '0;
    end else begin
      w_cnt_d = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1    <= i_btn;
      r_s2    <= r_s1;
      r_level <= w_level_d;
      r_cnt   <= w_cnt_d;
    end
  end

  assign o_level = r_level;
endmodule

// File: rtl/hdmi_timing_ctrl.sv
// Pixel-rate raster sequencer with sync/de decode and frame-aligned source select.
// Optional colour-bar generator built when TEST_PATTERN_EN is defined; otherwise rgb is 0.
module hdmi_timing_ctrl
  import hdmi_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE        = VGA_H_ACTIVE,
  parameter int unsigned H_FP            = VGA_H_FP,
  parameter int unsigned H_SYNC          = VGA_H_SYNC,
  parameter int unsigned H_BP            = VGA_H_BP,
  parameter int unsigned V_ACTIVE        = VGA_V_ACTIVE,
  parameter int unsigned V_FP            = VGA_V_FP,
  parameter int unsigned V_SYNC          = VGA_V_SYNC,
  parameter int unsigned V_BP            = VGA_V_BP,
  parameter bit          SYNC_POL        = VGA_SYNC_POL,
  parameter int unsigned DEBOUNCE_CYCLES = VGA_DEBOUNCE,
  parameter int unsigned CNT_W           = VGA_CNT_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              enable,
  input  logic              btn,
  hdmi_timing_ctrl_if.master vid
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] X_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] Y_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  state_t           r_state, w_state_d;
  logic [CNT_W-1:0] r_x, r_y, w_x_d, w_y_d;
  logic             w_last, w_active_d, w_fs_d, w_de_d, w_hs_d, w_vs_d, w_white_d;
  logic             r_de, r_hs, r_vs, r_fs, r_white;
  logic [23:0]      r_rgb, w_rgb_d;
  logic             w_btn_db;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .i_btn  (btn),
    .o_level(w_btn_db)
  );

  // Outputs are decoded from the next counter values so every registered output
  // lines up with the pixel_x/pixel_y it is shown alongside.
  always_comb begin
    w_state_d = r_state;
    w_x_d     = r_x;
    w_y_d     = r_y;
    w_last    = (r_x == X_LAST) && (r_y == Y_LAST);
    unique case (r_state)
      IDLE: begin
        w_x_d = '0;
        w_y_d = '0;
        if (enable) w_state_d = RUN;
      end
      RUN, DRAIN: begin
        w_state_d = enable ? RUN : DRAIN;
        if (w_last) begin
          w_x_d = '0;
          w_y_d = '0;
          if (!enable) w_state_d = IDLE;
        end else if (r_x == X_LAST) begin
          w_x_d = '0;
          w_y_d = r_y + 1'b1;
        end else begin
          w_x_d = r_x + 1'b1;
        end
      end
      default: w_state_d = IDLE;
    endcase

    w_active_d = (w_state_d != IDLE);
    w_fs_d     = w_active_d && (w_x_d == '0) && (w_y_d == '0);
    w_white_d  = w_fs_d ? w_btn_db : r_white;
    w_de_d     = w_active_d && (w_x_d < X_ACT) && (w_y_d < Y_ACT);
    w_hs_d     = (w_active_d && (w_x_d >= HS_START) && (w_x_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
    w_vs_d     = (w_active_d && (w_y_d >= VS_START) && (w_y_d < VS_END)) ? SYNC_POL : ~SYNC_POL;

    w_rgb_d = '0;
`ifdef TEST_PATTERN_EN
    if (w_de_d) begin
      w_rgb_d = w_white_d ? RGB_WHITE : bar_rgb(3'(w_x_d / CNT_W'(H_ACTIVE / 8)));
    end
`endif
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_de    <= 1'b0;
      r_hs    <= ~SYNC_POL;
      r_vs    <= ~SYNC_POL;
      r_fs    <= 1'b0;
      r_white <= 1'b0;
      r_rgb   <= '0;
    end else begin
      r_state <= w_state_d;
      r_x     <= w_x_d;
      r_y     <= w_y_d;
      r_de    <= w_de_d;
      r_hs    <= w_hs_d;
      r_vs    <= w_vs_d;
      r_fs    <= w_fs_d;
      r_white <= w_white_d;
      r_rgb   <= w_rgb_d;
    end
  end

  assign vid.pixel_x     = r_x;
  assign vid.pixel_y     = r_y;
  assign vid.de          = r_de;
  assign vid.hsync       = r_hs;
  assign vid.vsync       = r_vs;
  assign vid.frame_start = r_fs;
  assign vid.white_mode  = r_white;
  assign vid.rgb         = r_rgb;
endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Bench for hdmi_timing_ctrl on a shrunken raster; a frame-position model checks every cycle.
module tb_hdmi_timing_ctrl;
  localparam int unsigned HA = 16, HF = 2, HS = 4, HB = 2;
  localparam int unsigned VA = 8, VF = 2, VS = 2, VB = 2;
  localparam int unsigned HT = HA + HF + HS + HB;
  localparam int unsigned VT = VA + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT;
  localparam int unsigned DB = 50;

  logic clk = 1'b0;
  logic rst_n, enable, btn;
  bit   chk_on = 1'b0;
  int   n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  hdmi_timing_ctrl_if #(.CNT_W(10)) vif ();

  hdmi_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .DEBOUNCE_CYCLES(DB), .CNT_W(10)
  ) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .enable(enable),
    .btn   (btn),
    .vid   (vif)
  );

  // Reference model: running flag, linear position in frame, latched mode, debounced level.
  bit          m_run, m_white, m_db, m_fs;
  int unsigned m_p;
  bit          hist[$];
  logic [23:0] bars[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                           24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic model_reset();
    m_run = 0; m_p = 0; m_white = 0; m_db = 0; m_fs = 0;
    hist.delete();
    for (int i = 0; i <= DB; i++) hist.push_back(1'b0);
  endtask

  task automatic model_step();
    bit db_old, same;
    db_old = m_db;
    same = 1;
    // Two synchronizer stages: the window of the last DB samples ends two edges back.
    for (int i = 1; i < DB; i++) if (hist[i] != hist[0]) same = 0;
    if (same && hist[0] != m_db) m_db = hist[0];
    hist.push_back(btn);
    void'(hist.pop_front());
    m_fs = 0;
    if (!m_run) begin
      if (enable) begin m_run = 1; m_p = 0; m_fs = 1; end
    end else if (m_p == FRAME - 1) begin
      m_p = 0;
      if (enable) m_fs = 1; else m_run = 0;
    end else begin
      m_p++;
    end
    if (m_fs) m_white = db_old;
  endtask

  function automatic logic [48:0] exp_vec();
    int unsigned x, y;
    bit de, hs, vs;
    logic [23:0] rgb;
    x = m_p % HT;
    y = m_p / HT;
    de = m_run && x < HA && y < VA;
    hs = !(m_run && x >= HA + HF && x < HA + HF + HS);
    vs = !(m_run && y >= VA + VF && y < VA + VF + VS);
    rgb = 24'h0;
`ifdef TEST_PATTERN_EN
    if (de) rgb = m_white ? 24'hFFFFFF : bars[x / (HA / 8)];
`endif
    return {10'(x), 10'(y), de, hs, vs, m_fs, m_white, rgb};
  endfunction

  function automatic logic [48:0] act_vec();
    return {vif.pixel_x, vif.pixel_y, vif.de, vif.hsync, vif.vsync,
            vif.frame_start, vif.white_mode, vif.rgb};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic wait_pos(input int unsigned x, input int unsigned y, input int budget);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (vif.pixel_x == 10'(x) && vif.pixel_y == 10'(y)) hit = 1;
    end
    n_chk++;
    if (!hit) begin
      n_err++;
      $display("FAIL wait_pos: (%0d,%0d) not reached, got (%0d,%0d)", x, y,
               vif.pixel_x, vif.pixel_y);
    end
  endtask

  task automatic wait_fs(input int budget, output int cycles);
    bit hit = 0;
    cycles = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      cycles++;
      if (vif.frame_start) hit = 1;
    end
    n_chk++;
    if (!hit) begin
      n_err++;
      $display("FAIL wait_fs: no frame_start in %0d cycles, got 0 required 1", budget);
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (rst_n) model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) check("cycle", 64'(act_vec()), 64'(exp_vec()));
  end

  typedef struct {
    int unsigned x; int unsigned y;
    bit de; bit hs; bit vs; logic [23:0] rgb_pat;
  } vec_t;
  vec_t tbl[$];

  localparam logic [48:0] RST_VEC = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0};

  initial begin
    int cyc;
    logic [23:0] rgb_exp;
    tbl.push_back('{0, 0, 1, 1, 1, 24'hFFFFFF});
    tbl.push_back('{2, 1, 1, 1, 1, 24'hFFFF00});
    tbl.push_back('{15, 1, 1, 1, 1, 24'h000000});
    tbl.push_back('{16, 1, 0, 1, 1, 24'h0});
    tbl.push_back('{17, 3, 0, 1, 1, 24'h0});
    tbl.push_back('{18, 3, 0, 0, 1, 24'h0});
    tbl.push_back('{21, 3, 0, 0, 1, 24'h0});
    tbl.push_back('{22, 3, 0, 1, 1, 24'h0});
    tbl.push_back('{9, 5, 1, 1, 1, 24'hFF00FF});
    tbl.push_back('{23, 7, 0, 1, 1, 24'h0});
    tbl.push_back('{0, 8, 0, 1, 1, 24'h0});
    tbl.push_back('{5, 9, 0, 1, 1, 24'h0});
    tbl.push_back('{5, 10, 0, 1, 0, 24'h0});
    tbl.push_back('{19, 11, 0, 0, 0, 24'h0});
    tbl.push_back('{0, 12, 0, 1, 1, 24'h0});
    tbl.push_back('{23, 13, 0, 1, 1, 24'h0});

    rst_n = 0; enable = 0; btn = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset", 64'(act_vec()), 64'(RST_VEC));
    rst_n = 1;
    chk_on = 1;
    repeat (5) @(negedge clk);

    // Start-up: first RUN cycle is (0,0) with frame_start, then one frame period.
    enable = 1;
    @(negedge clk);
    check("first_run", {vif.pixel_x, vif.pixel_y, vif.frame_start}, {10'd0, 10'd0, 1'b1});
    wait_fs(2 * FRAME, cyc);
    check("fs_period", 64'(cyc), 64'(FRAME));

    foreach (tbl[i]) begin
      wait_pos(tbl[i].x, tbl[i].y, 2 * FRAME);
      rgb_exp = 24'h0;
`ifdef TEST_PATTERN_EN
      rgb_exp = tbl[i].rgb_pat;
`endif
      check($sformatf("tbl%0d", i), {vif.de, vif.hsync, vif.vsync, vif.rgb},
            {tbl[i].de, tbl[i].hs, tbl[i].vs, rgb_exp});
    end

    // Press mid-frame: mode must wait for the next frame boundary.
    wait_pos(5, 3, 2 * FRAME);
    btn = 1;
    repeat (DB + 10) @(negedge clk);
    check("white_hold", 64'(vif.white_mode), 64'd0);
    wait_fs(FRAME, cyc);
    rgb_exp = 24'h0;
`ifdef TEST_PATTERN_EN
    rgb_exp = 24'hFFFFFF;
`endif
    check("white_on", {vif.white_mode, vif.rgb}, {1'b1, rgb_exp});

    // Short glitches shorter than the debounce window must not change the level.
    wait_pos(0, 2, FRAME);
    btn = 0; repeat (20) @(negedge clk);
    btn = 1; repeat (20) @(negedge clk);
    btn = 0; repeat (20) @(negedge clk);
    btn = 1;
    wait_fs(FRAME, cyc);
    check("bounce_hi", 64'(vif.white_mode), 64'd1);
    wait_pos(0, 2, FRAME);
    btn = 0;
    wait_fs(FRAME, cyc);
    check("release", 64'(vif.white_mode), 64'd0);
    wait_pos(0, 2, FRAME);
    btn = 1; repeat (20) @(negedge clk);
    btn = 0; repeat (20) @(negedge clk);
    btn = 1; repeat (20) @(negedge clk);
    btn = 0;
    wait_fs(FRAME, cyc);
    check("bounce_lo", 64'(vif.white_mode), 64'd0);

    // Drain to idle.
    wait_pos(0, 3, FRAME);
    enable = 0;
    wait_pos(HT - 1, VT - 1, FRAME);
    @(negedge clk);
    check("drain_idle", {vif.pixel_x, vif.pixel_y, vif.de, vif.hsync, vif.vsync, vif.frame_start},
          {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0});
    repeat (10) @(negedge clk);
    check("idle_hold", 64'(act_vec()), 64'(RST_VEC));
    enable = 1;
    @(negedge clk);
    check("restart", {vif.pixel_x, vif.pixel_y, vif.frame_start}, {10'd0, 10'd0, 1'b1});

    // Re-enable during drain: raster continues without a gap.
    wait_pos(0, 4, FRAME);
    enable = 0;
    repeat (30) @(negedge clk);
    enable = 1;
    wait_pos(HT - 1, VT - 1, FRAME);
    @(negedge clk);
    check("drain_resume", {vif.pixel_x, vif.pixel_y, vif.frame_start}, {10'd0, 10'd0, 1'b1});

    // Randomized enable/btn traffic against the model.
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 59) == 0) btn = ~btn;
      if (!enable && $urandom_range(0, 49) == 0) enable = 1;
      else if (enable && $urandom_range(0, 599) == 0) enable = 0;
    end
    enable = 1;

    // Asynchronous reset mid-line.
    wait_pos(10, 2, 2 * FRAME + 10);
    #2 rst_n = 0;
    model_reset();
    #1 check("async_rst", 64'(act_vec()), 64'(RST_VEC));
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2 * FRAME) @(negedge clk);

    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
